uart_fifo: RTL and testbench

Parametrised synchronous FIFO/LIFO buffer for the UART datapath. It sits between the UART RX/TX byte interfaces and the interface/ALU control logic. It generalises the fixed 3-entry byte buffer to configurable width, power-of-two depth and selectable FIFO or LIFO ordering. It also adds registered read data with a valid strobe, a fill count, threshold flags and sticky error flags.

---
 rtl/uart_fifo_if.sv | 33 +++
 rtl/uart_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_if.sv
// uart_fifo_if: byte-path bundle between the UART RX/TX side and the buffer.
//   master: drives wr, w_data, rd, clr_err; observes read data, status, errors.
//   slave : the buffer itself; drives r_data, r_valid, fill flags, count, errors.
interface uart_fifo_if #(
    parameter int DBIT       = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  wr;
    logic [DBIT-1:0]       w_data;
    logic                  rd;
    logic                  clr_err;
    logic [DBIT-1:0]       r_data;
    logic                  r_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, w_data, rd, clr_err,
        input  r_data, r_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, clr_err,
        output r_data, r_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: parametrised FIFO/LIFO byte buffer for the UART datapath.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - asynchronous active-low reset (memory contents are kept)
//   bus   - uart_fifo_if slave: wr/w_data/rd/clr_err in; registered r_data,
//           one-cycle r_valid, empty/full/almost flags, count, sticky
//           overflow/underflow out. Every output comes straight from a flop.
module uart_fifo #(
    parameter int DBIT       = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int MODE       = 0,   // 0 = FIFO, 1 = LIFO
    parameter int AE_LEVEL   = 1,
    parameter int AF_LEVEL   = 3
) (
    input  logic         clk,
    input  logic         reset,
    uart_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_AE      = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_AF      = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    logic [DBIT-1:0]       r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DBIT-1:0]       r_rdata;
    logic                  r_rvalid;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_aempty;
    logic                  r_afull;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH-1:0] w_lifo_top;

    // Acceptance decode, next fill level and memory addressing.
    always_comb begin
        w_rd_ok      = 1'b0;
        w_wr_ok      = 1'b0;
        w_count_next = r_count;
        w_waddr      = r_wptr;
        w_raddr      = r_rptr;
        // Low bits wrap correctly even at count == DEPTH (0 - 1 = DEPTH-1).
        w_lifo_top   = r_count[ADDR_WIDTH-1:0] - C_PTR_ONE;

        w_rd_ok = bus.rd & ~r_empty;
        // A read in the same cycle frees a slot, so a full buffer still takes the write.
        w_wr_ok = bus.wr & (~r_full | w_rd_ok);

        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase

        if (MODE == 1) begin
            w_raddr = w_lifo_top;
            // On read+write the popped slot is reused for the pushed word.
            if (w_rd_ok) begin
                w_waddr = w_lifo_top;
            end else begin
                w_waddr = r_count[ADDR_WIDTH-1:0];
            end
        end else begin
            w_raddr = r_rptr;
            w_waddr = r_wptr;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_waddr] <= bus.w_data;
        end
    end

    // Pointers, count, registered flags, read data and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr  <= r_rptr + C_PTR_ONE;
                // Non-blocking read sees the pre-edge contents, so a LIFO
                // read+write returns the old top before it is overwritten.
                r_rdata <= r_mem[w_raddr];
            end
            r_rvalid <= w_rd_ok;
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_full   <= (w_count_next == C_DEPTH);
            r_aempty <= (w_count_next <= C_AE);
            r_afull  <= (w_count_next >= C_AF);
            // Setting has priority over clearing.
            if (bus.wr & ~w_wr_ok) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end
            if (bus.rd & ~w_rd_ok) begin
                r_unf <= 1'b1;
            end else if (bus.clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign bus.r_data       = r_rdata;
    assign bus.r_valid      = r_rvalid;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_aempty;
    assign bus.almost_full  = r_afull;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo, one FIFO and one LIFO instance
// sharing clock and reset; expected values are hand-computed constants.
module tb_uart_fifo;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    uart_fifo_if #(.DBIT(8), .ADDR_WIDTH(2)) fi ();
    uart_fifo_if #(.DBIT(8), .ADDR_WIDTH(2)) li ();

    uart_fifo #(.DBIT(8), .ADDR_WIDTH(2), .MODE(0), .AE_LEVEL(1), .AF_LEVEL(3))
        u_fifo (.clk(clk), .reset(rst_n), .bus(fi));
    uart_fifo #(.DBIT(8), .ADDR_WIDTH(2), .MODE(1), .AE_LEVEL(1), .AF_LEVEL(3))
        u_lifo (.clk(clk), .reset(rst_n), .bus(li));

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus on the selected instance (m=0 FIFO, m=1 LIFO).
    task automatic cyc(input int m, input logic w, input logic r,
                       input logic [7:0] d, input logic c);
        fi.wr = 1'b0; fi.rd = 1'b0; fi.w_data = 8'h00; fi.clr_err = 1'b0;
        li.wr = 1'b0; li.rd = 1'b0; li.w_data = 8'h00; li.clr_err = 1'b0;
        if (m == 0) begin
            fi.wr = w; fi.rd = r; fi.w_data = d; fi.clr_err = c;
        end else begin
            li.wr = w; li.rd = r; li.w_data = d; li.clr_err = c;
        end
        @(posedge clk);
        #1;
        fi.wr = 1'b0; fi.rd = 1'b0; fi.clr_err = 1'b0;
        li.wr = 1'b0; li.rd = 1'b0; li.clr_err = 1'b0;
    endtask

    task automatic fread(input string tag, input logic [7:0] exp);
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
        check({tag, "_data"}, 32'(fi.r_data), 32'(exp));
        check({tag, "_valid"}, 32'(fi.r_valid), 32'd1);
    endtask

    task automatic lread(input string tag, input logic [7:0] exp);
        cyc(1, 1'b0, 1'b1, 8'h00, 1'b0);
        check({tag, "_data"}, 32'(li.r_data), 32'(exp));
        check({tag, "_valid"}, 32'(li.r_valid), 32'd1);
    endtask

    initial begin
        logic [7:0] vals [4];
        n_checks = 0;
        n_errors = 0;
        fi.wr = 1'b0; fi.rd = 1'b0; fi.w_data = 8'h00; fi.clr_err = 1'b0;
        li.wr = 1'b0; li.rd = 1'b0; li.w_data = 8'h00; li.clr_err = 1'b0;

        // 1. reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_empty", 32'(fi.empty), 32'd1);
        check("rst_full", 32'(fi.full), 32'd0);
        check("rst_count", 32'(fi.count), 32'd0);
        check("rst_rdata", 32'(fi.r_data), 32'h00);
        check("rst_rvalid", 32'(fi.r_valid), 32'd0);
        check("rst_ovf", 32'(fi.overflow), 32'd0);
        check("rst_unf", 32'(fi.underflow), 32'd0);
        check("rst_aempty", 32'(fi.almost_empty), 32'd1);
        check("rst_afull", 32'(fi.almost_full), 32'd0);

        // 2. fill and overflow
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b1, 1'b0, vals[i], 1'b0);
            check("fill_count", 32'(fi.count), 32'(i + 1));
            check("fill_afull", 32'(fi.almost_full), (i >= 2) ? 32'd1 : 32'd0);
            check("fill_full", 32'(fi.full), (i == 3) ? 32'd1 : 32'd0);
        end
        cyc(0, 1'b1, 1'b0, 8'h55, 1'b0);
        check("ovf_set", 32'(fi.overflow), 32'd1);
        check("ovf_count", 32'(fi.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            fread("fill_rd", vals[i]);
        end
        check("drain_empty", 32'(fi.empty), 32'd1);
        check("drain_aempty", 32'(fi.almost_empty), 32'd1);
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rvalid_pulse", 32'(fi.r_valid), 32'd0);
        check("rdata_hold", 32'(fi.r_data), 32'h44);
        check("ovf_sticky", 32'(fi.overflow), 32'd1);
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(fi.overflow), 32'd0);

        // 3. wrap-around
        for (int i = 1; i <= 3; i++) cyc(0, 1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 1; i <= 3; i++) fread("wrap_a", 8'(i));
        for (int i = 4; i <= 7; i++) cyc(0, 1'b1, 1'b0, 8'(i), 1'b0);
        check("wrap_full", 32'(fi.full), 32'd1);
        for (int i = 4; i <= 7; i++) fread("wrap_b", 8'(i));
        check("wrap_empty", 32'(fi.empty), 32'd1);

        // 4. simultaneous read/write when full
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
        cyc(0, 1'b1, 1'b1, 8'hA4, 1'b0);
        check("rw_full_data", 32'(fi.r_data), 32'hA0);
        check("rw_full_valid", 32'(fi.r_valid), 32'd1);
        check("rw_full_count", 32'(fi.count), 32'd4);
        check("rw_full_ovf", 32'(fi.overflow), 32'd0);
        for (int i = 1; i <= 4; i++) fread("rw_full_rd", 8'hA0 + 8'(i));
        check("rw_full_empty", 32'(fi.empty), 32'd1);

        // 5. empty read and error clear
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("unf_set", 32'(fi.underflow), 32'd1);
        check("unf_rvalid", 32'(fi.r_valid), 32'd0);
        check("unf_rdata", 32'(fi.r_data), 32'hA4);
        check("unf_count", 32'(fi.count), 32'd0);
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_clr", 32'(fi.underflow), 32'd0);
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b1);
        check("unf_set_wins", 32'(fi.underflow), 32'd1);
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(0, 1'b1, 1'b1, 8'h5A, 1'b0);
        check("rw_empty_unf", 32'(fi.underflow), 32'd1);
        check("rw_empty_valid", 32'(fi.r_valid), 32'd0);
        check("rw_empty_count", 32'(fi.count), 32'd1);
        check("rw_empty_rdata", 32'(fi.r_data), 32'hA4);
        fread("rw_empty_rd", 8'h5A);

        // 6. LIFO ordering, read+write on a non-empty stack, async reset
        cyc(1, 1'b1, 1'b0, 8'hA1, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'hB2, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'hC3, 1'b0);
        check("lifo_count", 32'(li.count), 32'd3);
        lread("lifo_rd0", 8'hC3);
        lread("lifo_rd1", 8'hB2);
        lread("lifo_rd2", 8'hA1);
        check("lifo_empty", 32'(li.empty), 32'd1);
        cyc(1, 1'b1, 1'b0, 8'h10, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'h20, 1'b0);
        cyc(1, 1'b1, 1'b1, 8'h30, 1'b0);
        check("lifo_rw_data", 32'(li.r_data), 32'h20);
        check("lifo_rw_count", 32'(li.count), 32'd2);
        lread("lifo_rw_rd0", 8'h30);
        lread("lifo_rw_rd1", 8'h10);
        cyc(1, 1'b1, 1'b0, 8'h77, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'h88, 1'b0);
        check("lifo_pre_rst", 32'(li.count), 32'd2);
        rst_n = 1'b0;
        #2;
        check("lifo_rst_count", 32'(li.count), 32'd0);
        check("lifo_rst_empty", 32'(li.empty), 32'd1);
        check("lifo_rst_rdata", 32'(li.r_data), 32'h00);
        check("lifo_rst_rvalid", 32'(li.r_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("lifo_post_rst", 32'(li.count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
